// File: rtl/date_setter_pkg.sv
// date_setter_pkg: shared states, error codes and calendar limits for date_setter.
package date_setter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      YEAR,
      MONTH,
      DAY,
      WAIT,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE        = 2'd0;
   localparam logic [1:0] ERR_BAD_TARGET  = 2'd1;
   localparam logic [1:0] ERR_YEAR_BEHIND = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

   localparam int unsigned MONTHS_PER_YEAR = 12;
   localparam int unsigned MAX_DAY         = 31;

   // Day/month field width and settle counter width.
   localparam int unsigned DATE_W   = 7;
   localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/date_setter_pulse_spacer.sv
// date_setter_pulse_spacer: settle down-counter; load on each pulse, expired
// once SETTLE_CYCLES cycles (including the pulse cycle) have elapsed.
module date_setter_pulse_spacer
   import date_setter_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic expired_c
);

   logic [SETTLE_W-1:0] count;

   // Reload on a pulse, otherwise count down and rest at zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= SETTLE_W'(SETTLE_CYCLES - 1);
      end else if (count != '0) begin
         count <= count - SETTLE_W'(1);
      end
   end

   assign expired_c = (count == '0);

endmodule

// File: rtl/date_setter.sv
// date_setter: steps the calendar's year, then month, then day offset inputs
// until the reported date equals a latched target date.
// Optional macro DATE_SETTER_TIMEOUT_EN: per-phase pulse limit -> error 3.
module date_setter
   import date_setter_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned YEAR_W        = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [6:0]        target_day,
   input  logic [6:0]        target_month,
   input  logic [YEAR_W-1:0] target_year,
   input  logic [6:0]        cur_day,
   input  logic [6:0]        cur_month,
   input  logic [YEAR_W-1:0] cur_year,
   input  logic [6:0]        cur_max_days,
   output logic              day_increment,
   output logic              month_increment,
   output logic              year_increment,
   output logic              hold,
   output logic              busy,
   output logic              done,
   output logic [1:0]        error_code
);

   state_t              state, state_nxt;
   state_t              ret_phase, ret_nxt;
   logic [DATE_W-1:0]   tgt_day, tgt_month;
   logic [YEAR_W-1:0]   tgt_year;
   logic                latch, load, expired;
   logic                bad_target, month_limit, day_limit;
   logic                day_inc_nxt, month_inc_nxt, year_inc_nxt, done_nxt;
   logic [1:0]          err_nxt;

   assign bad_target = (tgt_month == '0) || (tgt_month > DATE_W'(MONTHS_PER_YEAR)) ||
                       (tgt_day == '0)   || (tgt_day > DATE_W'(MAX_DAY));

   date_setter_pulse_spacer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_pulse_spacer (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .expired_c (expired)
   );

`ifdef DATE_SETTER_TIMEOUT_EN
   localparam int unsigned PULSE_CNT_W = 6;
   logic [PULSE_CNT_W-1:0] pulse_cnt;

   // Pulses issued in the current month/day phase; cleared when a phase starts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pulse_cnt <= '0;
      end else if (state == IDLE || state == CHECK || (state == MONTH && state_nxt == DAY)) begin
         pulse_cnt <= '0;
      end else if (month_inc_nxt || day_inc_nxt) begin
         pulse_cnt <= pulse_cnt + PULSE_CNT_W'(1);
      end
   end

   assign month_limit = (pulse_cnt >= PULSE_CNT_W'(MONTHS_PER_YEAR));
   assign day_limit   = (pulse_cnt >= PULSE_CNT_W'(MAX_DAY));
`else
   assign month_limit = 1'b0;
   assign day_limit   = 1'b0;
`endif

   // State, return phase, latched targets and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ret_phase       <= IDLE;
         tgt_day         <= '0;
         tgt_month       <= '0;
         tgt_year        <= '0;
         day_increment   <= 1'b0;
         month_increment <= 1'b0;
         year_increment  <= 1'b0;
         done            <= 1'b0;
         busy            <= 1'b0;
         hold            <= 1'b0;
         error_code      <= ERR_NONE;
      end else begin
         state           <= state_nxt;
         ret_phase       <= ret_nxt;
         if (latch) begin
            tgt_day   <= target_day;
            tgt_month <= target_month;
            tgt_year  <= target_year;
         end
         day_increment   <= day_inc_nxt;
         month_increment <= month_inc_nxt;
         year_increment  <= year_inc_nxt;
         done            <= done_nxt;
         busy            <= (state_nxt != IDLE);
         hold            <= (state_nxt != IDLE);
         error_code      <= err_nxt;
      end
   end

   // Next state and next output values; abort overrides everything else.
   always_comb begin
      state_nxt     = state;
      ret_nxt       = ret_phase;
      err_nxt       = error_code;
      day_inc_nxt   = 1'b0;
      month_inc_nxt = 1'b0;
      year_inc_nxt  = 1'b0;
      done_nxt      = 1'b0;
      latch         = 1'b0;
      load          = 1'b0;
      if (state != IDLE && abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  latch     = 1'b1;
                  err_nxt   = ERR_NONE;
                  state_nxt = CHECK;
               end
            end
            CHECK: begin
               if (bad_target) begin
                  err_nxt   = ERR_BAD_TARGET;
                  state_nxt = ERR;
               end else if (tgt_year < cur_year) begin
                  err_nxt   = ERR_YEAR_BEHIND;
                  state_nxt = ERR;
               end else begin
                  state_nxt = YEAR;
               end
            end
            YEAR: begin
               if (cur_year == tgt_year) begin
                  state_nxt = MONTH;
               end else begin
                  year_inc_nxt = 1'b1;
                  load         = 1'b1;
                  ret_nxt      = YEAR;
                  state_nxt    = WAIT;
               end
            end
            MONTH: begin
               if (cur_month == tgt_month) begin
                  state_nxt = DAY;
               end else if (month_limit) begin
                  err_nxt   = ERR_TIMEOUT;
                  state_nxt = ERR;
               end else begin
                  month_inc_nxt = 1'b1;
                  load          = 1'b1;
                  ret_nxt       = MONTH;
                  state_nxt     = WAIT;
               end
            end
            DAY: begin
               if (tgt_day > cur_max_days) begin
                  err_nxt   = ERR_BAD_TARGET;
                  state_nxt = ERR;
               end else if (cur_day == tgt_day) begin
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end else if (day_limit) begin
                  err_nxt   = ERR_TIMEOUT;
                  state_nxt = ERR;
               end else begin
                  day_inc_nxt = 1'b1;
                  load        = 1'b1;
                  ret_nxt     = DAY;
                  state_nxt   = WAIT;
               end
            end
            WAIT: begin
               if (expired) begin
                  state_nxt = ret_phase;
               end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
